la_iopwrseq: RTL and testbench



---
 rtl/la_iopwrseq.sv | 200 ++++++++++++++++++++
 tb/tb_la_iopwrseq.sv | 121 ++++++++++++
 2 files changed

// File: rtl/la_iopwrseq.sv
// la_iopwrseq: brings N io-ring supply domains up in order and down in reverse order, each qualified by its power-good.
// Build option LA_IOPWRSEQ_SYNC_EN places a 2-flop synchroniser on every pgood bit.
module la_iopwrseq #(
    parameter int N       = 3,
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 16,
    parameter int GAP     = 2
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         req,
    input  logic [N-1:0] pgood,
    output logic [N-1:0] en,
    output logic         ack,
    output logic         fault
);
    localparam int IW   = (N > 1) ? $clog2(N) : 1;
    localparam int CMAX = (SETTLE > TIMEOUT) ? ((SETTLE > GAP) ? SETTLE : GAP)
                                             : ((TIMEOUT > GAP) ? TIMEOUT : GAP);
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] GAP_END      = CW'(GAP);
    localparam logic [CW-1:0] CNT_ZERO     = {CW{1'b0}};
    localparam logic [IW-1:0] IDX_LAST     = IW'(N - 1);
    localparam logic [IW-1:0] IDX_ONE      = IW'(1);
    localparam logic [IW-1:0] IDX_ZERO     = {IW{1'b0}};

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_UP    = 3'd1,
        ST_ON    = 3'd2,
        ST_DOWN  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [CW-1:0] scnt_q, scnt_d;
    logic [CW-1:0] tcnt_q, tcnt_d;
    logic [N-1:0]  en_q, en_d;
    logic          ack_q, ack_d;
    logic          fault_q, fault_d;
    logic [N-1:0]  pg;
    logic          lost_s, settle_s, timeout_s;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + CW'(1);
    endfunction

`ifdef LA_IOPWRSEQ_SYNC_EN
    logic [N-1:0] sync1_q, sync2_q;

    // Two-stage synchroniser for the asynchronous power-good detectors
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sync1_q <= {N{1'b0}};
            sync2_q <= {N{1'b0}};
        end else begin
            sync1_q <= pgood;
            sync2_q <= sync1_q;
        end
    end

    assign pg = sync2_q;
`else
    assign pg = pgood;
`endif

    // Sequencer next-state: fault beats abort/down, which beats normal progress
    always_comb begin
        lost_s = 1'b0;
        for (int j = 0; j < N; j++) begin
            lost_s = lost_s | ((j < int'(idx_q)) & ~pg[j]);
        end
        settle_s  = pg[idx_q] && (scnt_q >= SETTLE_LAST);
        timeout_s = !settle_s && (tcnt_q >= TIMEOUT_LAST);

        state_d = state_q;
        idx_d   = idx_q;
        scnt_d  = scnt_q;
        tcnt_d  = tcnt_q;
        en_d    = en_q;

        case (state_q)
            ST_OFF: begin
                en_d   = {N{1'b0}};
                idx_d  = IDX_ZERO;
                scnt_d = CNT_ZERO;
                tcnt_d = CNT_ZERO;
                if (req) begin
                    state_d = ST_UP;
                    en_d[0] = 1'b1;
                end else begin
                    state_d = ST_OFF;
                end
            end
            ST_UP: begin
                if (lost_s || timeout_s) begin
                    state_d = ST_FAULT;
                    en_d    = {N{1'b0}};
                    scnt_d  = CNT_ZERO;
                    tcnt_d  = CNT_ZERO;
                end else if (!req) begin
                    state_d     = ST_DOWN;
                    en_d[idx_q] = 1'b0;
                    scnt_d      = CNT_ZERO;
                    tcnt_d      = CNT_ZERO;
                end else if (settle_s) begin
                    scnt_d = CNT_ZERO;
                    tcnt_d = CNT_ZERO;
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_ON;
                    end else begin
                        idx_d                 = idx_q + IDX_ONE;
                        en_d[idx_q + IDX_ONE] = 1'b1;
                    end
                end else begin
                    tcnt_d = sat_inc(tcnt_q);
                    scnt_d = pg[idx_q] ? sat_inc(scnt_q) : CNT_ZERO;
                end
            end
            ST_ON: begin
                if (!(&pg)) begin
                    state_d = ST_FAULT;
                    en_d    = {N{1'b0}};
                end else if (!req) begin
                    state_d        = ST_DOWN;
                    idx_d          = IDX_LAST;
                    en_d[IDX_LAST] = 1'b0;
                    scnt_d         = CNT_ZERO;
                end else begin
                    state_d = ST_ON;
                end
            end
            ST_DOWN: begin
                // scnt doubles as the post-drop gap timer; pg is deliberately ignored here
                if (scnt_q >= GAP_END) begin
                    scnt_d = CNT_ZERO;
                    if (idx_q == IDX_ZERO) begin
                        state_d = ST_OFF;
                    end else begin
                        idx_d                 = idx_q - IDX_ONE;
                        en_d[idx_q - IDX_ONE] = 1'b0;
                    end
                end else begin
                    scnt_d = sat_inc(scnt_q);
                end
            end
            ST_FAULT: begin
                en_d   = {N{1'b0}};
                scnt_d = CNT_ZERO;
                tcnt_d = CNT_ZERO;
                if (!req) begin
                    state_d = ST_OFF;
                    idx_d   = IDX_ZERO;
                end else begin
                    state_d = ST_FAULT;
                end
            end
            default: begin
                state_d = ST_OFF;
                idx_d   = IDX_ZERO;
                scnt_d  = CNT_ZERO;
                tcnt_d  = CNT_ZERO;
                en_d    = {N{1'b0}};
            end
        endcase

        ack_d   = (state_d == ST_ON);
        fault_d = (state_d == ST_FAULT);
    end

    // Sequencer state and registered outputs
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= ST_OFF;
            idx_q   <= IDX_ZERO;
            scnt_q  <= CNT_ZERO;
            tcnt_q  <= CNT_ZERO;
            en_q    <= {N{1'b0}};
            ack_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            scnt_q  <= scnt_d;
            tcnt_q  <= tcnt_d;
            en_q    <= en_d;
            ack_q   <= ack_d;
            fault_q <= fault_d;
        end
    end

    assign en    = en_q;
    assign ack   = ack_q;
    assign fault = fault_q;

endmodule

// File: tb/tb_la_iopwrseq.sv
// Self-checking bench for la_iopwrseq (N=3, SETTLE=4, TIMEOUT=16, GAP=2, no pgood synchroniser).
// Expected {en,ack,fault} per cycle is queued at drive time and compared one cycle later.
module tb_la_iopwrseq;
    logic       clk    = 1'b0;
    logic       nreset = 1'b1;
    logic       req    = 1'b0;
    logic [2:0] pgood  = 3'b000;
    logic [2:0] en;
    logic       ack;
    logic       fault;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [4:0] exp_q[$];
    string      tag_q[$];

    la_iopwrseq #(
        .N      (3),
        .SETTLE (4),
        .TIMEOUT(16),
        .GAP    (2)
    ) dut (
        .clk   (clk),
        .nreset(nreset),
        .req   (req),
        .pgood (pgood),
        .en    (en),
        .ack   (ack),
        .fault (fault)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of stimulus and queue what {en,ack,fault} must be after the next edge
    task automatic drive(input logic r, input logic [2:0] p, input logic [2:0] e_en,
                         input logic e_ack, input logic e_fault, input string tag);
        @(negedge clk);
        req   = r;
        pgood = p;
        exp_q.push_back({e_en, e_ack, e_fault});
        tag_q.push_back(tag);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                check_eq(tag_q.pop_front(), 32'({en, ack, fault}), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        #1 nreset = 1'b0;
        #1 check_eq("reset_state", 32'({en, ack, fault}), 32'(0));
        repeat (2) @(negedge clk);
        nreset = 1'b1;

        // pgood[k] follows en[k] by 2 cycles; each domain settles 6 cycles after its enable
        for (int t = 0; t < 20; t++)
            drive(1'b1, {t >= 15, t >= 9, t >= 3},
                  (t < 6) ? 3'b001 : ((t < 12) ? 3'b011 : 3'b111),
                  t >= 18, 1'b0, $sformatf("up_t%0d", t));

        // Power-down from ON; pgood collapses and req returns early, both ignored until OFF
        for (int t = 0; t < 11; t++)
            drive(t >= 7, (t < 2) ? 3'b111 : 3'b000,
                  (t < 3) ? 3'b011 : ((t < 6) ? 3'b001 : ((t < 10) ? 3'b000 : 3'b001)),
                  1'b0, 1'b0, $sformatf("down_t%0d", t));

        for (int u = 0; u < 26; u++)
            drive(u < 24, {2'b00, u >= 2},
                  (u < 5) ? 3'b001 : ((u < 21) ? 3'b011 : 3'b000),
                  1'b0, (u >= 21) && (u < 24), $sformatf("timeout_u%0d", u));

        for (int v = 0; v < 25; v++)
            drive(1'b1, {v >= 19, v >= 13, ((v >= 3) && (v <= 5)) || (v >= 7)},
                  (v < 10) ? 3'b001 : ((v < 16) ? 3'b011 : 3'b111),
                  v >= 22, 1'b0, $sformatf("glitch_v%0d", v));

        for (int w = 0; w < 3; w++)
            drive(1'b0, (w == 0) ? 3'b011 : 3'b000, 3'b000, 1'b0, w == 0,
                  $sformatf("loss_on_w%0d", w));

        for (int x = 0; x < 8; x++)
            drive(1'b1, {2'b00, x >= 3}, (x < 6) ? 3'b001 : 3'b011, 1'b0, 1'b0,
                  $sformatf("pre_reset_x%0d", x));

        @(posedge clk);
        #3 nreset = 1'b0;
        #1 check_eq("reset_async", 32'({en, ack, fault}), 32'(0));
        @(negedge clk);
        req   = 1'b0;
        pgood = 3'b000;
        #2 nreset = 1'b1;

        for (int y = 0; y < 10; y++)
            drive(1'b1, {2'b00, y >= 3}, (y < 6) ? 3'b001 : 3'b011, 1'b0, 1'b0,
                  $sformatf("restart_y%0d", y));

        @(posedge clk);
        #2 check_eq("sb_drain", 32'(exp_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
